// File: rtl/imem_loader.sv
// Serial boot loader: receives a length-prefixed program image over an 8N1 UART line,
// writes it into imem from word 0 upward and holds the core in reset until the image is complete.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [31:0]      MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HDR_HI, HDR_LO, DATA, DONE} ld_state_t;

  // ---------------- input synchronizer ----------------
  logic rxd_meta, rxd_sync;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would make rxd_sync see rxd in the same edge and collapse the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // ---------------- UART receiver ----------------
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_cnt_clr;
  logic             byte_valid;
  logic             frame_err;

  // NOTE: every signal written here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    rx_next    = rx_state;
    rx_cnt_clr = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          rx_next    = RX_START;
          rx_cnt_clr = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_clr = 1'b1;
          rx_next    = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_clr = 1'b1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        // Back to idle right after the mid-bit sample so a following start edge is not missed.
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_clr = 1'b1;
          rx_next    = RX_IDLE;
          byte_valid = rxd_sync;
          frame_err  = !rxd_sync;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rxd_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- image loader ----------------
  ld_state_t        ld_state, ld_next;
  logic [7:0]       hdr_hi;
  logic [15:0]      words_left;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      hdr_n;
  logic             in_image;
  logic             tmo_hit;
  logic             start_img, enter_data, word_full, finish, abort;

  always_comb begin
    hdr_n      = {16'd0, hdr_hi, rx_shift};
    in_image   = (ld_state == HDR_LO) || (ld_state == DATA);
    tmo_hit    = in_image && (tmo_cnt == TMO_LAST) && !byte_valid;
    ld_next    = ld_state;
    start_img  = 1'b0;
    enter_data = 1'b0;
    word_full  = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    if (frame_err) begin
      ld_next = HDR_HI;
      abort   = 1'b1;
    end else begin
      case (ld_state)
        HDR_HI, DONE: begin
          if (byte_valid) begin
            ld_next   = HDR_LO;
            start_img = 1'b1;
          end
        end
        HDR_LO: begin
          if (byte_valid) begin
            if (hdr_n == 32'd0) begin
              ld_next = DONE;
              finish  = 1'b1;
            end else if (hdr_n > MAX_WORDS) begin
              ld_next = HDR_HI;
              abort   = 1'b1;
            end else begin
              ld_next    = DATA;
              enter_data = 1'b1;
            end
          end else if (tmo_hit) begin
            ld_next = HDR_HI;
            abort   = 1'b1;
          end
        end
        DATA: begin
          // words_left reaches 0 on the last word's 4th byte; its strobe cycle closes the image.
          if (byte_valid) begin
            word_full = (byte_idx == 2'd3);
          end else if (imem_we && words_left == 16'd0) begin
            ld_next = DONE;
            finish  = 1'b1;
          end else if (tmo_hit) begin
            ld_next = HDR_HI;
            abort   = 1'b1;
          end
        end
        default: ld_next = HDR_HI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state   <= HDR_HI;
      hdr_hi     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      tmo_cnt    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ld_state <= ld_next;
      err      <= abort;
      imem_we  <= word_full;
      tmo_cnt  <= (byte_valid || !in_image) ? '0 : tmo_cnt + 1'b1;
      if (start_img) begin
        hdr_hi  <= rx_shift;
        busy    <= 1'b1;
        done    <= 1'b0;
        cpu_rst <= 1'b1;
      end
      if (abort) busy <= 1'b0;
      if (finish) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
      if (enter_data) begin
        words_left <= hdr_n[15:0];
        byte_idx   <= '0;
        imem_addr  <= '0;
      end
      if (ld_state == DATA && byte_valid) begin
        asm_q    <= {asm_q[15:0], rx_shift};
        byte_idx <= byte_idx + 2'd1;
        if (word_full) begin
          imem_wdata <= {asm_q, rx_shift};
          words_left <= words_left - 16'd1;
        end
      end
      if (imem_we) imem_addr <= imem_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives 8N1 bytes at 16 clks/bit and checks the
// imem writes, status flags, timeout, framing error, glitch rejection and async reset.
module tb_imem_loader;
  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxd = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst, busy, done, err;

  int errors = 0, checks = 0;
  int cyc = 0, err_cnt = 0, last_we_cyc = -1, fall_cyc = -1, we_double = 0, err_long = 0;
  int b, e0, waited;
  logic prev_we = 1'b0, prev_err = 1'b0, prev_cpu_rst = 1'b1;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Passive monitor on the falling edge: records writes, err pulses and the cpu_rst release.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (imem_we && prev_we) we_double++;
    if (err) err_cnt++;
    if (err && prev_err) err_long++;
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_we      = imem_we;
    prev_err     = err;
    prev_cpu_rst = cpu_rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset values while rst is held
    #1 rst = 1'b1;
    #1;
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: two-word image
    b = wr_addr.size();
    send_byte(8'h00, 1'b1);
    check("t1_busy_hdr", busy, 1);
    check("t1_cpu_rst_hdr", cpu_rst, 1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    check("t1_cpu_rst_mid", cpu_rst, 1);
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1); send_byte(8'h45, 1'b1); send_byte(8'h67, 1'b1);
    repeat (5) @(negedge clk);
    check("t1_nwrites", wr_addr.size() - b, 2);
    check("t1_addr0", 32'(wr_addr[b]), 0);
    check("t1_data0", wr_data[b], 32'hDEADBEEF);
    check("t1_addr1", 32'(wr_addr[b+1]), 1);
    check("t1_data1", wr_data[b+1], 32'h01234567);
    check("t1_cpu_rst_fall", fall_cyc, last_we_cyc + 1);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_cpu_rst", cpu_rst, 0);

    // 2: empty image
    b = wr_addr.size();
    send_byte(8'h00, 1'b1);
    check("t2_done_cleared", done, 0);
    check("t2_cpu_rst_hdr", cpu_rst, 1);
    send_byte(8'h00, 1'b1);
    check("t2_nwrites", wr_addr.size() - b, 0);
    check("t2_done", done, 1);
    check("t2_cpu_rst", cpu_rst, 0);
    check("t2_busy", busy, 0);

    // 3: oversize count, then a valid one-word image
    b  = wr_addr.size();
    e0 = err_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    check("t3_err", err_cnt - e0, 1);
    check("t3_nwrites", wr_addr.size() - b, 0);
    check("t3_cpu_rst", cpu_rst, 1);
    check("t3_busy", busy, 0);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_nwrites2", wr_addr.size() - b, 1);
    check("t3_addr0", 32'(wr_addr[b]), 0);
    check("t3_data0", wr_data[b], 32'h11223344);
    check("t3_done", done, 1);

    // 4: timeout on a partial word
    b  = wr_addr.size();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    e0     = err_cnt;
    waited = 0;
    while (err_cnt == e0 && waited < 2600) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("t4_err", err_cnt - e0, 1);
    check("t4_latency", 32'(waited > 1900 && waited < 2100), 1);
    check("t4_nwrites", wr_addr.size() - b, 0);
    check("t4_cpu_rst", cpu_rst, 1);
    check("t4_busy", busy, 0);

    // 5: framing error inside DATA, then an idle-line glitch, then a clean image
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hAA, 1'b1);
    e0 = err_cnt;
    send_byte(8'h5A, 1'b0);
    check("t5_frame_err", err_cnt - e0, 1);
    check("t5_busy", busy, 0);
    check("t5_cpu_rst", cpu_rst, 1);
    e0 = err_cnt;
    b  = wr_addr.size();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_glitch_err", err_cnt - e0, 0);
    check("t5_glitch_busy", busy, 0);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1); send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_nwrites", wr_addr.size() - b, 1);
    check("t5_data0", wr_data[b], 32'h55667788);
    check("t5_done", done, 1);

    // 6: reload while done, then async reset mid-word
    b = wr_addr.size();
    send_byte(8'h00, 1'b1);
    check("t6_cpu_rst_hdr", cpu_rst, 1);
    check("t6_done_cleared", done, 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'hCA, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'hBA, 1'b1); send_byte(8'hBE, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_addr0", 32'(wr_addr[b]), 0);
    check("t6_data0", wr_data[b], 32'hCAFEBABE);
    check("t6_cpu_rst", cpu_rst, 0);
    check("t6_done", done, 1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    check("t6_busy_pre_rst", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_wdata", imem_wdata, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_cpu_rst", cpu_rst, 1);
    check("t6_async_done", done, 0);
    check("t6_async_we", imem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    b = wr_addr.size();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_post_rst_addr", 32'(wr_addr[b]), 0);
    check("t6_post_rst_data", wr_data[b], 32'h01020304);
    check("t6_post_rst_done", done, 1);

    check("we_never_double", we_double, 0);
    check("err_single_pulse", err_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
